// File: rtl/mem_line_writer.sv
// mem_line_writer: accepts one line write request and serializes its enabled
// bytes onto a byte-wide write port. It pulses resp_valid when the line is
// done and keeps a saturating count of tainted bytes written.
module mem_line_writer #(
    parameter int unsigned IS_VARIANT = 0,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned ADDR_WIDTH = 31
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_valid_taint_0,
    output logic                    req_ready,
    input  logic [63:0]             req_addr,
    input  logic [LINE_BYTES*8-1:0] req_data,
    input  logic [LINE_BYTES*8-1:0] req_data_taint_0,
    input  logic [LINE_BYTES-1:0]   req_mask,
    output logic                    mem_wr_valid,
    input  logic                    mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [7:0]              mem_wr_data,
    output logic [7:0]              mem_wr_data_taint_0,
    output logic                    mem_wr_variant,
    output logic                    resp_valid,
    output logic [31:0]             taint_sum
);

    localparam int unsigned IDX_W  = $clog2(LINE_BYTES);
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_BYTES - 1);
    localparam logic [31:0] SUM_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]     data_q, data_d;
    logic [LINE_W-1:0]     taint_q, taint_d;
    logic [LINE_BYTES-1:0] mask_q, mask_d;
    logic [31:0]           sum_q, sum_d;

    logic                  ready_q, ready_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [7:0]            wr_taint_q, wr_taint_d;
    logic                  resp_q, resp_d;

    // Upper address bits and the request-valid taint have no function here.
    logic unused_bits;
    assign unused_bits = &{1'b0, req_valid_taint_0, req_addr[63:ADDR_WIDTH]};

    // Extract byte i of a line-wide vector.
    function automatic logic [7:0] byte_of(input logic [LINE_W-1:0] v,
                                           input logic [IDX_W-1:0]  i);
        return v[{i, 3'b000} +: 8];
    endfunction

    // Next-state, datapath capture and next registered output values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        taint_d = taint_q;
        mask_d  = mask_q;
        sum_d   = sum_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_WIDTH-1:0];
                    data_d  = req_data;
                    taint_d = req_data_taint_0;
                    mask_d  = req_mask;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A disabled byte costs one skip cycle; an enabled one waits for ready.
                if (!mask_q[idx_q] || mem_wr_ready) begin
                    if (mask_q[idx_q] && (|byte_of(taint_q, idx_q)) && (sum_q != SUM_MAX)) begin
                        sum_d = sum_q + 32'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = RESP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d    = (state_d == IDLE);
        wr_valid_d = (state_d == WRITE) && mask_d[idx_d];
        wr_addr_d  = '0;
        wr_data_d  = '0;
        wr_taint_d = '0;
        if (wr_valid_d) begin
            // 31-bit add wraps naturally past the top of the address space.
            wr_addr_d  = addr_d + ADDR_WIDTH'(idx_d);
            wr_data_d  = byte_of(data_d, idx_d);
            wr_taint_d = byte_of(taint_d, idx_d);
        end
        resp_d = (state_d == RESP);
    end

    // State, captured line and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            taint_q    <= '0;
            mask_q     <= '0;
            sum_q      <= '0;
            ready_q    <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_taint_q <= '0;
            resp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            taint_q    <= taint_d;
            mask_q     <= mask_d;
            sum_q      <= sum_d;
            ready_q    <= ready_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_taint_q <= wr_taint_d;
            resp_q     <= resp_d;
        end
    end

    assign req_ready           = ready_q;
    assign mem_wr_valid        = wr_valid_q;
    assign mem_wr_addr         = wr_addr_q;
    assign mem_wr_data         = wr_data_q;
    assign mem_wr_data_taint_0 = wr_taint_q;
    assign resp_valid          = resp_q;
    assign taint_sum           = sum_q;
    assign mem_wr_variant      = 1'(IS_VARIANT % 2);

endmodule

// File: tb/tb_mem_line_writer.sv
// Testbench for mem_line_writer: directed and randomized lines checked against
// a queue-based reference of the expected byte writes, latency and taint count.
module tb_mem_line_writer;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_valid_taint_0;
    logic         req_ready;
    logic [63:0]  req_addr;
    logic [255:0] req_data;
    logic [255:0] req_data_taint_0;
    logic [31:0]  req_mask;
    logic         mem_wr_valid;
    logic         mem_wr_ready;
    logic [30:0]  mem_wr_addr;
    logic [7:0]   mem_wr_data;
    logic [7:0]   mem_wr_data_taint_0;
    logic         mem_wr_variant;
    logic         resp_valid;
    logic [31:0]  taint_sum;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_sum = 32'd0;

    mem_line_writer #(.IS_VARIANT(0), .LINE_BYTES(32), .ADDR_WIDTH(31)) dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_valid_taint_0   (req_valid_taint_0),
        .req_ready           (req_ready),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .req_data_taint_0    (req_data_taint_0),
        .req_mask            (req_mask),
        .mem_wr_valid        (mem_wr_valid),
        .mem_wr_ready        (mem_wr_ready),
        .mem_wr_addr         (mem_wr_addr),
        .mem_wr_data         (mem_wr_data),
        .mem_wr_data_taint_0 (mem_wr_data_taint_0),
        .mem_wr_variant      (mem_wr_variant),
        .resp_valid          (resp_valid),
        .taint_sum           (taint_sum)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] sparse_taint();
        logic [255:0] r;
        for (int i = 0; i < 32; i++)
            r[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        return r;
    endfunction

    // mode 0: ready always 1; mode 1: random ready; mode 2: ready low for cycles 1..3
    task automatic run_line(input logic [63:0] a, input logic [255:0] d,
                            input logic [255:0] t, input logic [31:0] m, input int mode);
        logic [46:0] q[$];
        int   k;
        int   stalls;
        bit   done;
        bit   prev_stall;
        logic rdy;
        for (int i = 0; i < 32; i++)
            if (m[i]) q.push_back({31'(a[30:0] + 31'(i)), d[i*8 +: 8], t[i*8 +: 8]});
        req_valid        = 1'b1;
        req_addr         = a;
        req_data         = d;
        req_data_taint_0 = t;
        req_mask         = m;
        mem_wr_ready     = 1'b0;
        @(posedge clock); #1;
        k = 1; stalls = 0; done = 0; prev_stall = 0;
        while (!done && k < 200) begin
            if (k == 1) check("req_ready_busy", 64'(req_ready), 64'd0);
            if (prev_stall) check("valid_held", 64'(mem_wr_valid), 64'd1);
            if (mem_wr_valid) begin
                if (q.size() == 0) check("extra_write", 64'd1, 64'd0);
                else begin
                    check("wr_addr", 64'(mem_wr_addr), 64'(q[0][46:16]));
                    check("wr_data", 64'(mem_wr_data), 64'(q[0][15:8]));
                    check("wr_taint", 64'(mem_wr_data_taint_0), 64'(q[0][7:0]));
                end
            end
            if (resp_valid) begin
                check("resp_latency", 64'(k), 64'(33 + stalls));
                check("writes_left", 64'(q.size()), 64'd0);
                done = 1;
                req_valid = 1'b0;
            end else begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: rdy = (k >= 4);
                endcase
                mem_wr_ready = rdy;
                if (mem_wr_valid && !rdy) stalls++;
                if (mem_wr_valid && rdy && q.size() > 0) begin
                    if ((q[0][7:0] != 8'h00) && (exp_sum != 32'hFFFF_FFFF)) exp_sum = exp_sum + 32'd1;
                    void'(q.pop_front());
                end
                prev_stall = mem_wr_valid && !rdy;
                // Requests offered while busy must be ignored.
                req_valid        = 1'($urandom_range(0, 1));
                req_addr         = {$urandom, $urandom};
                req_data         = rand256();
                req_data_taint_0 = rand256();
                req_mask         = $urandom;
            end
            @(posedge clock); #1;
            k++;
        end
        if (!done) check("resp_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        check("resp_one_cycle", 64'(resp_valid), 64'd0);
        check("req_ready_after", 64'(req_ready), 64'd1);
        check("taint_sum", 64'(taint_sum), 64'(exp_sum));
    endtask

    initial begin
        logic [255:0] d;
        logic [255:0] t;
        logic [63:0]  a;
        logic [31:0]  m;
        int           bad;

        reset = 1'b0; req_valid = 1'b0; req_valid_taint_0 = 1'b0;
        req_addr = '0; req_data = '0; req_data_taint_0 = '0; req_mask = '0; mem_wr_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
        check("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        check("rst_wr_data", 64'(mem_wr_data), 64'd0);
        check("rst_wr_taint", 64'(mem_wr_data_taint_0), 64'd0);
        check("rst_resp", 64'(resp_valid), 64'd0);
        check("rst_taint_sum", 64'(taint_sum), 64'd0);
        check("variant", 64'(mem_wr_variant), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Full mask, byte i = i, upper address bit dropped.
        for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(i);
        run_line(64'h8000_1000, d, '0, 32'hFFFF_FFFF, 0);
        // Sparse mask: bytes 0 and 2 only.
        run_line(64'h0000_2003, rand256(), '0, 32'h0000_0005, 0);
        // Backpressure on byte 0 for three cycles.
        run_line(64'h0000_3000, rand256(), '0, 32'hFFFF_FFFF, 2);
        // Address wrap mid-line.
        run_line(64'h7FFF_FFF0, rand256(), '0, 32'hFFFF_FFFF, 0);
        // Two tainted bytes.
        t = '0; t[3*8 +: 8] = 8'h01; t[7*8 +: 8] = 8'h80;
        run_line(64'h0000_4000, rand256(), t, 32'hFFFF_FFFF, 0);
        check("taint_two", 64'(taint_sum), 64'd2);
        // Empty mask: no writes, sum unchanged, response still pulses.
        run_line(64'h0000_5000, rand256(), '1, 32'h0, 0);
        check("taint_mask0", 64'(taint_sum), 64'd2);

        // Randomized lines under random backpressure.
        for (int n = 0; n < 16; n++) begin
            a = {$urandom, $urandom};
            if (n % 4 == 1) a[30:0] = 31'h7FFF_FFE0 + 31'($urandom_range(0, 31));
            case (n % 5)
                0:       m = 32'hFFFF_FFFF;
                1:       m = 32'h0;
                default: m = $urandom;
            endcase
            run_line(a, rand256(), sparse_taint(), m, 1);
        end

        // Reset in the middle of a line aborts it.
        req_valid = 1'b1; req_addr = 64'h100; req_data = rand256();
        req_data_taint_0 = '1; req_mask = 32'hFFFF_FFFF; mem_wr_ready = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (9) begin
            @(posedge clock); #1;
        end
        check("pre_reset_valid", 64'(mem_wr_valid), 64'd1);
        check("pre_reset_addr", 64'(mem_wr_addr), 64'h109);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_sum = 32'd0;
        check("mid_rst_wr_valid", 64'(mem_wr_valid), 64'd0);
        check("mid_rst_taint_sum", 64'(taint_sum), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (c == 0) check("release_req_ready", 64'(req_ready), 64'd1);
            if (mem_wr_valid || resp_valid) bad++;
        end
        check("no_activity_after_reset", 64'(bad), 64'd0);
        check("taint_after_reset", 64'(taint_sum), 64'd0);

        // Block still works after the abort.
        run_line(64'h0000_6000, rand256(), sparse_taint(), $urandom, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
